memory_bus_controller: RTL and testbench

Sequences CPU memory transactions onto the physical memory ports, sitting directly downstream of the address bus mux and consuming its 16-bit `ADDRESS_BUS`. Decodes each access into either a synchronous block RAM (fixed read latency) or the memory-mapped I/O window (variable latency, ready handshake). Drives `BUSY` back to the control unit so it stalls until the access completes.

---
 rtl/memory_bus_pkg.sv | 20 ++
 rtl/memory_bus_controller_timeout.sv | 48 ++++
 rtl/memory_bus_controller.sv | 208 ++++++++++++++++++++
 tb/tb_memory_bus_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_pkg.sv
// Shared types and constants for the memory bus controller: FSM state
// encoding, default I/O window base and the value returned by an aborted read.
package memory_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAM_WR = 2'd1,
        RAM_RD = 2'd2,
        IO_ACC = 2'd3
    } membus_state_t;

    localparam logic [15:0] IO_BASE_DEFAULT  = 16'hFF00;
    localparam logic [63:0] READ_ABORT_VALUE = {64{1'b1}};

    // The window starts at base and never crosses into another 256-byte page.
    function automatic logic in_io_window(input logic [15:0] addr, input logic [15:0] base);
        return (addr >= base) && (addr[15:8] == base[15:8]);
    endfunction

endpackage

// File: rtl/memory_bus_controller_timeout.sv
// bus_timeout_counter: counts enabled cycles since the last clear and flags
// (registered) the cycle in which the limit-th enabled cycle is reached.
module bus_timeout_counter
    import memory_bus_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_r;
    logic             expired_r;
    logic [CNT_W:0]   cnt_plus2_s;

    // Look-ahead so expired lines up with the count that follows this edge.
    always_comb begin
        cnt_plus2_s = {1'b0, cnt_r} + {{(CNT_W-1){1'b0}}, 2'd2};
    end

    // Counter and registered expiry flag; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            expired_r <= 1'b0;
        end else if (clear) begin
            cnt_r     <= {CNT_W{1'b0}};
            expired_r <= (limit <= {{(CNT_W-1){1'b0}}, 1'b1});
        end else if (enable) begin
            if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            expired_r <= (cnt_plus2_s >= {1'b0, limit});
        end else begin
            cnt_r     <= cnt_r;
            expired_r <= expired_r;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/memory_bus_controller.sv
// Memory bus controller: routes CPU accesses to block RAM or the I/O window.
// Optional I/O watchdog is enabled by defining MEMBUS_TIMEOUT_EN.
module memory_bus_controller
    import memory_bus_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned RAM_LATENCY    = 1,
    parameter logic [15:0] IO_BASE        = IO_BASE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [15:0]       ADDRESS_BUS,
    input  logic [DATA_W-1:0] WRITE_DATA,
    input  logic              MEM_READ,
    input  logic              MEM_WRITE,
    output logic [DATA_W-1:0] READ_DATA,
    output logic              READ_VALID,
    output logic              BUSY,
    output logic [15:0]       RAM_ADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    output logic              RAM_WE,
    input  logic [DATA_W-1:0] RAM_RDATA,
    output logic [7:0]        IO_ADDR,
    output logic [DATA_W-1:0] IO_WDATA,
    output logic              IO_RD,
    output logic              IO_WR,
    input  logic [DATA_W-1:0] IO_RDATA,
    input  logic              IO_READY,
    output logic              BUS_ERROR
);

    localparam logic [2:0] LAT_LAST = 3'(RAM_LATENCY - 1);

    if (RAM_LATENCY < 1 || RAM_LATENCY > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("memory_bus_controller: RAM_LATENCY must be 1..4 and TIMEOUT_CYCLES 1..65535");
    end

    membus_state_t     state_r, next_state_s;
    logic [15:0]       addr_r, addr_nxt_s;
    logic [DATA_W-1:0] wdata_r, wdata_nxt_s;
    logic              is_write_r, is_write_nxt_s;
    logic [2:0]        lat_cnt_r, lat_cnt_nxt_s;
    logic [DATA_W-1:0] read_data_r, read_data_nxt_s;
    logic              read_valid_r, read_valid_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              ram_we_r, ram_we_nxt_s;
    logic              io_rd_r, io_rd_nxt_s;
    logic              io_wr_r, io_wr_nxt_s;
    logic              bus_error_r, bus_error_nxt_s;

`ifdef MEMBUS_TIMEOUT_EN
    logic tmo_clear_s;
    logic tmo_enable_s;
    logic tmo_expired_s;

    bus_timeout_counter #(
        .CNT_W (16)
    ) u_timeout (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clear   (tmo_clear_s),
        .enable  (tmo_enable_s),
        .limit   (16'(TIMEOUT_CYCLES)),
        .expired (tmo_expired_s)
    );
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        next_state_s     = state_r;
        addr_nxt_s       = addr_r;
        wdata_nxt_s      = wdata_r;
        is_write_nxt_s   = is_write_r;
        lat_cnt_nxt_s    = lat_cnt_r;
        read_data_nxt_s  = read_data_r;
        read_valid_nxt_s = 1'b0;
        busy_nxt_s       = busy_r;
        ram_we_nxt_s     = 1'b0;
        io_rd_nxt_s      = 1'b0;
        io_wr_nxt_s      = 1'b0;
        bus_error_nxt_s  = 1'b0;
`ifdef MEMBUS_TIMEOUT_EN
        tmo_clear_s      = 1'b0;
        tmo_enable_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                busy_nxt_s = 1'b0;
                if (MEM_READ || MEM_WRITE) begin
                    addr_nxt_s     = ADDRESS_BUS;
                    wdata_nxt_s    = WRITE_DATA;
                    is_write_nxt_s = MEM_WRITE;
                    lat_cnt_nxt_s  = 3'd0;
                    busy_nxt_s     = 1'b1;
                    if (in_io_window(ADDRESS_BUS, IO_BASE)) begin
                        next_state_s = IO_ACC;
                        io_wr_nxt_s  = MEM_WRITE;
                        io_rd_nxt_s  = ~MEM_WRITE;
`ifdef MEMBUS_TIMEOUT_EN
                        tmo_clear_s  = 1'b1;
`endif
                    end else if (MEM_WRITE) begin
                        next_state_s = RAM_WR;
                        ram_we_nxt_s = 1'b1;
                    end else begin
                        next_state_s = RAM_RD;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RAM_WR: begin
                next_state_s = IDLE;
                busy_nxt_s   = 1'b0;
            end
            RAM_RD: begin
                if (lat_cnt_r == LAT_LAST) begin
                    next_state_s     = IDLE;
                    busy_nxt_s       = 1'b0;
                    read_data_nxt_s  = RAM_RDATA;
                    read_valid_nxt_s = 1'b1;
                end else begin
                    lat_cnt_nxt_s = lat_cnt_r + 3'd1;
                end
            end
            IO_ACC: begin
`ifdef MEMBUS_TIMEOUT_EN
                tmo_enable_s = 1'b1;
`endif
                // IO_READY wins over a watchdog expiring on the same edge.
                if (IO_READY) begin
                    next_state_s = IDLE;
                    busy_nxt_s   = 1'b0;
                    if (!is_write_r) begin
                        read_data_nxt_s  = IO_RDATA;
                        read_valid_nxt_s = 1'b1;
                    end else begin
                        read_data_nxt_s  = read_data_r;
                    end
`ifdef MEMBUS_TIMEOUT_EN
                end else if (tmo_expired_s) begin
                    next_state_s    = IDLE;
                    busy_nxt_s      = 1'b0;
                    bus_error_nxt_s = 1'b1;
                    if (!is_write_r) begin
                        read_data_nxt_s  = READ_ABORT_VALUE[DATA_W-1:0];
                        read_valid_nxt_s = 1'b1;
                    end else begin
                        read_data_nxt_s  = read_data_r;
                    end
`endif
                end else begin
                    io_rd_nxt_s = ~is_write_r;
                    io_wr_nxt_s = is_write_r;
                end
            end
            default: begin
                next_state_s = IDLE;
                busy_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops every strobe immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= IDLE;
            addr_r       <= 16'h0000;
            wdata_r      <= {DATA_W{1'b0}};
            is_write_r   <= 1'b0;
            lat_cnt_r    <= 3'd0;
            read_data_r  <= {DATA_W{1'b0}};
            read_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            ram_we_r     <= 1'b0;
            io_rd_r      <= 1'b0;
            io_wr_r      <= 1'b0;
            bus_error_r  <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            addr_r       <= addr_nxt_s;
            wdata_r      <= wdata_nxt_s;
            is_write_r   <= is_write_nxt_s;
            lat_cnt_r    <= lat_cnt_nxt_s;
            read_data_r  <= read_data_nxt_s;
            read_valid_r <= read_valid_nxt_s;
            busy_r       <= busy_nxt_s;
            ram_we_r     <= ram_we_nxt_s;
            io_rd_r      <= io_rd_nxt_s;
            io_wr_r      <= io_wr_nxt_s;
            bus_error_r  <= bus_error_nxt_s;
        end
    end

    assign READ_DATA  = read_data_r;
    assign READ_VALID = read_valid_r;
    assign BUSY       = busy_r;
    assign RAM_ADDR   = addr_r;
    assign RAM_WDATA  = wdata_r;
    assign RAM_WE     = ram_we_r;
    assign IO_ADDR    = addr_r[7:0];
    assign IO_WDATA   = wdata_r;
    assign IO_RD      = io_rd_r;
    assign IO_WR      = io_wr_r;
    assign BUS_ERROR  = bus_error_r;

endmodule

// File: tb/tb_memory_bus_controller.sv
// Bench for memory_bus_controller: directed table, random transactions against
// a transaction-level model, plus latency-3, reset-abort and timeout sequences.
module tb_memory_bus_controller;

    localparam int TMO = 8;
    localparam int LAT = 1;
`ifdef MEMBUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] address_bus;
    logic [7:0]  write_data;
    logic        mem_read, mem_write;
    logic [7:0]  read_data;
    logic        read_valid, busy;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_we;
    logic [7:0]  io_addr, io_wdata, io_rdata;
    logic        io_rd, io_wr, io_ready, bus_error;

    logic [15:0] a3;
    logic [7:0]  wd3, read_data3, ram_wdata3, ram_rdata3, io_addr3, io_wdata3;
    logic        rd3, wr3, read_valid3, busy3, ram_we3, io_rd3, io_wr3, bus_error3;
    logic [15:0] ram_addr3;

    memory_bus_controller #(.DATA_W(8), .RAM_LATENCY(LAT), .IO_BASE(16'hFF00), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(clk), .RST_N(rst_n), .ADDRESS_BUS(address_bus), .WRITE_DATA(write_data),
        .MEM_READ(mem_read), .MEM_WRITE(mem_write), .READ_DATA(read_data), .READ_VALID(read_valid),
        .BUSY(busy), .RAM_ADDR(ram_addr), .RAM_WDATA(ram_wdata), .RAM_WE(ram_we), .RAM_RDATA(ram_rdata),
        .IO_ADDR(io_addr), .IO_WDATA(io_wdata), .IO_RD(io_rd), .IO_WR(io_wr), .IO_RDATA(io_rdata),
        .IO_READY(io_ready), .BUS_ERROR(bus_error));

    memory_bus_controller #(.DATA_W(8), .RAM_LATENCY(3), .IO_BASE(16'hFF00), .TIMEOUT_CYCLES(TMO)) dut3 (
        .CLK(clk), .RST_N(rst_n), .ADDRESS_BUS(a3), .WRITE_DATA(wd3),
        .MEM_READ(rd3), .MEM_WRITE(wr3), .READ_DATA(read_data3), .READ_VALID(read_valid3),
        .BUSY(busy3), .RAM_ADDR(ram_addr3), .RAM_WDATA(ram_wdata3), .RAM_WE(ram_we3), .RAM_RDATA(ram_rdata3),
        .IO_ADDR(io_addr3), .IO_WDATA(io_wdata3), .IO_RD(io_rd3), .IO_WR(io_wr3), .IO_RDATA(8'h00),
        .IO_READY(1'b1), .BUS_ERROR(bus_error3));

    always #5 clk = ~clk;

    // Environment RAMs: latency 1 is a combinational read, latency 3 adds two stages.
    logic [7:0] ram  [0:65535];
    logic [7:0] ram3 [0:65535];
    logic [7:0] pipe3 [0:1];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) begin
        if (ram_we3) ram3[ram_addr3] <= ram_wdata3;
        pipe3[0] <= ram3[ram_addr3];
        pipe3[1] <= pipe3[0];
    end
    assign ram_rdata3 = pipe3[1];

    int total = 0;
    int bad = 0;

    // Transaction-level reference state.
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] written_q [$];
    logic [7:0]  last_rd = 8'h00;

    typedef struct {
        logic [15:0] a; logic [7:0] wd; logic rd; logic wr; int d; logic [7:0] iod; logic poke;
        int e_done; int e_we; int e_io; int e_rv; logic [7:0] e_rdata; int e_err;
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected outcome of one access, straight from the access rules; updates model state.
    task automatic predict(input logic [15:0] a, input logic [7:0] wd, input logic wr, input int d,
                           input logic [7:0] iod, output int e_done, output int e_we, output int e_io,
                           output int e_rv, output logic [7:0] e_rdata, output int e_err);
        e_we = 0; e_io = 0; e_rv = 0; e_err = 0; e_rdata = last_rd;
        if (a < 16'hFF00) begin
            if (wr) begin
                e_done = 2; e_we = 1;
                ref_mem[a] = wd;
                written_q.push_back(a);
            end else begin
                e_done = 1 + LAT; e_rv = 1; e_rdata = ref_mem[a];
            end
        end else if (TMO_EN && d > TMO) begin
            e_io = TMO; e_done = TMO + 1; e_err = 1;
            if (!wr) begin e_rv = 1; e_rdata = 8'hFF; end
        end else begin
            e_io = d; e_done = d + 1;
            if (!wr) begin e_rv = 1; e_rdata = iod; end
        end
        if (e_rv != 0) last_rd = e_rdata;
    endtask

    // Drive one access and observe it cycle by cycle until BUSY drops.
    task automatic run_txn(input vec_t v, output int done, output int we_n, output int io_n, output int rv_n,
                           output logic [7:0] rdat, output int err_n, output int bad_n, output int rv_c, output int err_c);
        done = -1; we_n = 0; io_n = 0; rv_n = 0; err_n = 0; bad_n = 0; rdat = 8'h00; rv_c = -1; err_c = -1;
        address_bus = v.a; write_data = v.wd; mem_read = v.rd; mem_write = v.wr; io_rdata = v.iod; io_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            mem_read = 1'b0;
            if (ram_we) begin
                we_n++;
                if (ram_addr !== v.a || ram_wdata !== v.wd) bad_n++;
            end
            if (io_rd || io_wr) begin
                io_n++;
                if (io_addr !== v.a[7:0] || (io_rd && io_wr) || (io_wr && io_wdata !== v.wd)) bad_n++;
            end
            if (read_valid) begin rv_n++; rdat = read_data; rv_c = c; end
            if (bus_error) begin err_n++; err_c = c; end
            if (!busy) begin done = c; break; end
            if (v.poke && c == 1) mem_read = 1'b1;
            io_ready = (io_rd || io_wr) && (io_n >= v.d);
            @(negedge clk);
        end
        io_ready = 1'b0;
        mem_read = 1'b0;
    endtask

    task automatic check_txn(input string tag, input vec_t v, input int e_done, input int e_we, input int e_io,
                             input int e_rv, input logic [7:0] e_rdata, input int e_err);
        int done, we_n, io_n, rv_n, err_n, bad_n, rv_c, err_c;
        logic [7:0] rdat;
        run_txn(v, done, we_n, io_n, rv_n, rdat, err_n, bad_n, rv_c, err_c);
        check({tag, "_done"}, done, e_done);
        check({tag, "_ram_we"}, we_n, e_we);
        check({tag, "_io_strobe"}, io_n, e_io);
        check({tag, "_read_valid"}, rv_n, e_rv);
        check({tag, "_bus_error"}, err_n, e_err);
        check({tag, "_addr_data"}, bad_n, 0);
        if (e_rv != 0) check({tag, "_read_data"}, rdat, e_rdata);
        if (e_err != 0) check({tag, "_err_with_rv"}, err_c, (e_rv != 0) ? rv_c : err_c);
        @(negedge clk);
        check({tag, "_idle_after"}, {busy, read_valid, ram_we, io_rd, io_wr}, 5'b0);
    endtask

    initial begin
        int rv3c, n;
        logic [7:0] rdat3;
        int e_done, e_we, e_io, e_rv, e_err;
        logic [7:0] e_rdata;
        vec_t v;

        vecs[0]  = '{16'h0010, 8'hA5, 1'b0, 1'b1, 0, 8'h00, 1'b0, 2, 1, 0, 0, 8'h00, 0};
        vecs[1]  = '{16'h0010, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 2, 0, 0, 1, 8'hA5, 0};
        vecs[2]  = '{16'hFF04, 8'h00, 1'b1, 1'b0, 5, 8'h3C, 1'b1, 6, 0, 5, 1, 8'h3C, 0};
        vecs[3]  = '{16'h0020, 8'h77, 1'b1, 1'b1, 0, 8'h00, 1'b0, 2, 1, 0, 0, 8'h00, 0};
        vecs[4]  = '{16'h0020, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 2, 0, 0, 1, 8'h77, 0};
        vecs[5]  = '{16'hFEFF, 8'h5E, 1'b0, 1'b1, 0, 8'h00, 1'b0, 2, 1, 0, 0, 8'h00, 0};
        vecs[6]  = '{16'hFEFF, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 2, 0, 0, 1, 8'h5E, 0};
        vecs[7]  = '{16'hFF00, 8'hC3, 1'b0, 1'b1, 1, 8'h00, 1'b0, 2, 0, 1, 0, 8'h00, 0};
        vecs[8]  = '{16'hFFFF, 8'h00, 1'b1, 1'b0, 1, 8'h81, 1'b0, 2, 0, 1, 1, 8'h81, 0};
        vecs[9]  = '{16'hFF40, 8'h99, 1'b0, 1'b1, 3, 8'h00, 1'b1, 4, 0, 3, 0, 8'h00, 0};
        vecs[10] = '{16'h0010, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 2, 0, 0, 1, 8'hA5, 0};

        rst_n = 1'b1;
        address_bus = 16'h0000; write_data = 8'h00; mem_read = 1'b0; mem_write = 1'b0;
        io_rdata = 8'h00; io_ready = 1'b0;
        a3 = 16'h0000; wd3 = 8'h00; rd3 = 1'b0; wr3 = 1'b0;
        #1 rst_n = 1'b0;
        #3;
        check("reset_outputs", {read_data, read_valid, busy, ram_addr, ram_wdata, ram_we,
                                io_addr, io_wdata, io_rd, io_wr, bus_error}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency-3 instance: two writes, then a read whose data must appear in cycle N+4.
        a3 = 16'h0000; wd3 = 8'h5A; wr3 = 1'b1;
        @(posedge clk); @(negedge clk); wr3 = 1'b0;
        repeat (2) @(negedge clk);
        a3 = 16'h0010; wd3 = 8'hA5; wr3 = 1'b1;
        @(posedge clk); @(negedge clk); wr3 = 1'b0;
        repeat (2) @(negedge clk);
        a3 = 16'h0000; rd3 = 1'b1; rv3c = -1; n = 0; rdat3 = 8'h00;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            rd3 = 1'b0;
            if (read_valid3) begin
                n++;
                if (rv3c < 0) begin rv3c = c; rdat3 = read_data3; end
            end
            if (c == 3) check("lat3_busy_mid", busy3, 1'b1);
        end
        check("lat3_valid_cycle", rv3c, 4);
        check("lat3_valid_count", n, 1);
        check("lat3_read_data", rdat3, 8'h5A);

        for (int i = 0; i < 11; i++) begin
            check_txn($sformatf("vec%0d", i), vecs[i], vecs[i].e_done, vecs[i].e_we, vecs[i].e_io,
                      vecs[i].e_rv, vecs[i].e_rdata, vecs[i].e_err);
            predict(vecs[i].a, vecs[i].wd, vecs[i].wr, vecs[i].d, vecs[i].iod,
                    e_done, e_we, e_io, e_rv, e_rdata, e_err);
            check($sformatf("vec%0d_hold", i), read_data, last_rd);
        end

        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            v.wd = 8'($urandom); v.iod = 8'($urandom); v.poke = 1'($urandom_range(0, 1));
            v.d = int'($urandom_range(1, TMO_EN ? 12 : 6));
            v.rd = 1'b0; v.wr = 1'b0;
            case (kind)
                0: begin
                    v.a = ($urandom_range(0, 1) == 1) ? {8'h00, 8'($urandom)} : {8'hFE, 8'($urandom)};
                    v.wr = 1'b1; v.rd = 1'($urandom_range(0, 1));
                end
                1: begin
                    v.a = written_q[$urandom_range(0, written_q.size() - 1)];
                    v.rd = 1'b1;
                end
                2: begin
                    v.a = {8'hFF, 8'($urandom)};
                    v.rd = 1'b1;
                end
                default: begin
                    v.a = {8'hFF, 8'($urandom)};
                    v.wr = 1'b1; v.rd = 1'($urandom_range(0, 1));
                end
            endcase
            predict(v.a, v.wd, v.wr, v.d, v.iod, e_done, e_we, e_io, e_rv, e_rdata, e_err);
            check_txn($sformatf("rnd%0d", i), v, e_done, e_we, e_io, e_rv, e_rdata, e_err);
            check($sformatf("rnd%0d_hold", i), read_data, last_rd);
        end

`ifdef MEMBUS_TIMEOUT_EN
        v = '{16'hFF08, 8'h00, 1'b1, 1'b0, 1000, 8'h11, 1'b0, 0, 0, 0, 0, 8'h00, 0};
        check_txn("timeout", v, TMO + 1, 0, TMO, 1, 8'hFF, 1);
        last_rd = 8'hFF;
        check("timeout_hold", read_data, 8'hFF);
`else
        check("bus_error_tied", bus_error, 1'b0);
`endif

        // Reset in the middle of an I/O read that never completes.
        address_bus = 16'hFF02; mem_read = 1'b1; io_ready = 1'b0;
        @(posedge clk); @(negedge clk); mem_read = 1'b0;
        @(negedge clk);
        check("rst_pre_io_rd", io_rd, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_strobes", {io_rd, io_wr, ram_we, busy, read_valid}, 5'b0);
        check("rst_async_read_data", read_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (read_valid || busy || io_rd) n++;
        end
        check("rst_no_late_valid", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
